pc_npc_sequencer: RTL and testbench

Parametrised PC/nPC sequencer for the SPARC pipeline front end. It folds next-PC source selection, the PC/nPC register pair and the adder into one block, and adds four things: delayed-transfer semantics, delay-slot annulment, trap redirection, and JMPL target alignment checking. It sits between the ID-stage control decode and instruction fetch, and drives the fetch address each enabled cycle.

---
 rtl/pc_npc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_npc_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pc_npc_sequencer.sv
// SPARC front-end PC/nPC sequencer: next-PC selection, delayed transfers,
// delay-slot annulment, trap redirection and JMPL target alignment check.
`timescale 1ns/1ps
module pc_npc_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int INC        = 4,
  parameter int RESET_PC   = 0,
  parameter int ALIGN_BITS = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  le,
  input  logic                  trap_req,
  input  logic [ADDR_WIDTH-1:0] trap_vec,
  input  logic                  jmpl,
  input  logic                  call,
  input  logic                  br_taken,
  input  logic                  br_annul,
  input  logic                  br_always,
  input  logic [ADDR_WIDTH-1:0] alu_out,
  input  logic [ADDR_WIDTH-1:0] ta,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] npc,
  output logic                  annul_slot,
  output logic [1:0]            src_sel,
  output logic                  misalign_err
);

  localparam logic [ADDR_WIDTH-1:0] INC_W   = ADDR_WIDTH'(INC);
  localparam logic [ADDR_WIDTH-1:0] RESET_W = ADDR_WIDTH'(RESET_PC);

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_TA   = 2'b01;
  localparam logic [1:0] SRC_ALU  = 2'b10;
  localparam logic [1:0] SRC_TRAP = 2'b11;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] npc_q, npc_d;
  logic                  annul_q, annul_d;
  logic [1:0]            src_q, src_d;
  logic                  err_q, err_d;

  logic jmpl_e_s, call_e_s, taken_e_s, annul_e_s, misaligned_s;

  // An annulled instruction contributes no control transfer; traps are never masked.
  assign jmpl_e_s     = jmpl      & ~annul_q;
  assign call_e_s     = call      & ~annul_q;
  assign taken_e_s    = br_taken  & ~annul_q;
  assign annul_e_s    = br_annul  & ~annul_q;
  assign misaligned_s = |alu_out[ALIGN_BITS-1:0];

  // Next-state selection: trap > jmpl > call/taken branch > sequential.
  always_comb begin
    pc_d    = pc_q;
    npc_d   = npc_q;
    annul_d = annul_q;
    src_d   = src_q;
    err_d   = 1'b0;
    if (le) begin
      if (trap_req) begin
        pc_d    = trap_vec;
        npc_d   = trap_vec + INC_W;
        annul_d = 1'b0;
        src_d   = SRC_TRAP;
      end else if (jmpl_e_s) begin
        src_d = SRC_ALU;
        if (misaligned_s) begin
          err_d = 1'b1;
        end else begin
          pc_d    = npc_q;
          npc_d   = alu_out;
          annul_d = 1'b0;
        end
      end else if (call_e_s || taken_e_s) begin
        pc_d    = npc_q;
        npc_d   = ta;
        src_d   = SRC_TA;
        annul_d = br_annul & br_always & ~call;
      end else begin
        // Not-taken branch with the annul bit squashes its delay slot.
        pc_d    = npc_q;
        npc_d   = npc_q + INC_W;
        src_d   = SRC_SEQ;
        annul_d = annul_e_s;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q    <= RESET_W;
      npc_q   <= RESET_W + INC_W;
      annul_q <= 1'b0;
      src_q   <= SRC_SEQ;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      annul_q <= annul_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

  assign pc           = pc_q;
  assign npc          = npc_q;
  assign annul_slot   = annul_q;
  assign src_sel      = src_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Bench for pc_npc_sequencer: a transfer-level model checked every cycle,
// plus directed scenarios with literal expected states.
`timescale 1ns/1ps
module tb_pc_npc_sequencer;

  localparam int AW = 32;

  logic          clk = 1'b0, clr = 1'b1, le = 1'b1;
  logic          trap_req = 1'b0, jmpl = 1'b0, call = 1'b0;
  logic          br_taken = 1'b0, br_annul = 1'b0, br_always = 1'b0;
  logic [AW-1:0] trap_vec = '0, alu_out = '0, ta = '0;
  logic [AW-1:0] pc, npc;
  logic          annul_slot, misalign_err;
  logic [1:0]    src_sel;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        annul;
    logic [1:0]  src;
    logic        err;
  } st_t;

  st_t m;

  pc_npc_sequencer #(.ADDR_WIDTH(AW), .INC(4), .RESET_PC(0), .ALIGN_BITS(2)) dut (
    .clk(clk), .clr(clr), .le(le), .trap_req(trap_req), .trap_vec(trap_vec),
    .jmpl(jmpl), .call(call), .br_taken(br_taken), .br_annul(br_annul),
    .br_always(br_always), .alu_out(alu_out), .ta(ta), .pc(pc), .npc(npc),
    .annul_slot(annul_slot), .src_sel(src_sel), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // SPARC delayed-transfer semantics: every non-trap advance moves npc into pc.
  function automatic st_t model_next(st_t s);
    st_t n;
    logic live;
    live  = !s.annul;
    n     = s;
    n.err = 1'b0;
    if (trap_req) begin
      n.pc = trap_vec; n.npc = trap_vec + 32'd4; n.annul = 1'b0; n.src = 2'd3;
    end else if (live && jmpl && (alu_out % 32'd4) != 32'd0) begin
      n.err = 1'b1; n.src = 2'd2;
    end else begin
      n.pc = s.npc;
      if (live && jmpl) begin
        n.npc = alu_out; n.src = 2'd2; n.annul = 1'b0;
      end else if (live && (call || br_taken)) begin
        n.npc = ta; n.src = 2'd1; n.annul = br_annul && br_always && !call;
      end else begin
        n.npc = s.npc + 32'd4; n.src = 2'd0; n.annul = live && br_annul;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr)    m <= {32'h0, 32'h4, 1'b0, 2'b00, 1'b0};
    else if (le) m <= model_next(m);
    else         m.err <= 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model comparison away from the active edge.
  always @(negedge clk) begin
    chk("model_pc", pc, m.pc);
    chk("model_npc", npc, m.npc);
    chk("model_annul", {31'd0, annul_slot}, {31'd0, m.annul});
    chk("model_src", {30'd0, src_sel}, {30'd0, m.src});
    chk("model_err", {31'd0, misalign_err}, {31'd0, m.err});
  end

  task automatic expect_state(input string n, input logic [31:0] p, input logic [31:0] np,
                              input logic an, input logic [1:0] s, input logic e);
    chk({n, "_pc"}, pc, p);
    chk({n, "_npc"}, npc, np);
    chk({n, "_annul"}, {31'd0, annul_slot}, {31'd0, an});
    chk({n, "_src"}, {30'd0, src_sel}, {30'd0, s});
    chk({n, "_err"}, {31'd0, misalign_err}, {31'd0, e});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trap_req = 1'b0; jmpl = 1'b0; call = 1'b0;
    br_taken = 1'b0; br_annul = 1'b0; br_always = 1'b0;
  endtask

  initial begin
    #2 clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    expect_state("reset", 32'h0, 32'h4, 1'b0, 2'b00, 1'b0);

    step(); expect_state("seq1", 32'h4, 32'h8, 1'b0, 2'b00, 1'b0);
    step(); expect_state("seq2", 32'h8, 32'hC, 1'b0, 2'b00, 1'b0);
    step(); expect_state("seq3", 32'hC, 32'h10, 1'b0, 2'b00, 1'b0);
    step(); expect_state("seq4", 32'h10, 32'h14, 1'b0, 2'b00, 1'b0);

    br_taken = 1'b1; ta = 32'h100;
    step(); expect_state("br_slot", 32'h14, 32'h100, 1'b0, 2'b01, 1'b0);
    idle();
    step(); expect_state("br_tgt", 32'h100, 32'h104, 1'b0, 2'b00, 1'b0);

    trap_req = 1'b1; trap_vec = 32'h20;
    step(); expect_state("trap20", 32'h20, 32'h24, 1'b0, 2'b11, 1'b0);
    idle();
    br_taken = 1'b1; br_always = 1'b1; br_annul = 1'b1; ta = 32'h200;
    step(); expect_state("ba_a", 32'h24, 32'h200, 1'b1, 2'b01, 1'b0);
    idle(); jmpl = 1'b1; alu_out = 32'h300;
    step(); expect_state("ba_a_tgt", 32'h200, 32'h204, 1'b0, 2'b00, 1'b0);
    idle();

    trap_req = 1'b1; trap_vec = 32'h40;
    step(); expect_state("trap40", 32'h40, 32'h44, 1'b0, 2'b11, 1'b0);
    idle(); jmpl = 1'b1; alu_out = 32'h302;
    step(); expect_state("jmpl_mis", 32'h40, 32'h44, 1'b0, 2'b10, 1'b1);
    alu_out = 32'h300;
    step(); expect_state("jmpl_ok", 32'h44, 32'h300, 1'b0, 2'b10, 1'b0);
    idle();

    br_annul = 1'b1;
    step(); expect_state("nt_annul", 32'h300, 32'h304, 1'b1, 2'b00, 1'b0);
    idle(); trap_req = 1'b1; trap_vec = 32'h800; call = 1'b1; ta = 32'h900;
    step(); expect_state("trap_over", 32'h800, 32'h804, 1'b0, 2'b11, 1'b0);
    idle();

    jmpl = 1'b1; alu_out = 32'h700; call = 1'b1; ta = 32'h900;
    step(); expect_state("jmpl_wins", 32'h804, 32'h700, 1'b0, 2'b10, 1'b0);
    idle();

    call = 1'b1; ta = 32'h500;
    step(); expect_state("dcti1", 32'h700, 32'h500, 1'b0, 2'b01, 1'b0);
    idle(); br_taken = 1'b1; ta = 32'h600;
    step(); expect_state("dcti2", 32'h500, 32'h600, 1'b0, 2'b01, 1'b0);
    idle();
    step(); expect_state("dcti3", 32'h600, 32'h604, 1'b0, 2'b00, 1'b0);

    trap_req = 1'b1; trap_vec = 32'hFFFF_FFF8;
    step(); expect_state("trap_hi", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0, 2'b11, 1'b0);
    idle();
    step(); expect_state("wrap1", 32'hFFFF_FFFC, 32'h0, 1'b0, 2'b00, 1'b0);
    step(); expect_state("wrap2", 32'h0, 32'h4, 1'b0, 2'b00, 1'b0);

    le = 1'b0; call = 1'b1; ta = 32'h900;
    step(); expect_state("hold1", 32'h0, 32'h4, 1'b0, 2'b00, 1'b0);
    step(); expect_state("hold2", 32'h0, 32'h4, 1'b0, 2'b00, 1'b0);
    le = 1'b1; idle();

    br_annul = 1'b1;
    step(); expect_state("pre_clr", 32'h4, 32'h8, 1'b1, 2'b00, 1'b0);
    idle();
    #3 clr = 1'b0;
    #1 expect_state("async_clr", 32'h0, 32'h4, 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #1 clr = 1'b1;
    step(); expect_state("post_clr", 32'h4, 32'h8, 1'b0, 2'b00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
